// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline slice: fetch FSM encodings,
// control opcodes and reset defaults.
package mips_pipe_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, stall hold buffer,
// redirect squashing and the IF/ID pipeline register.
module fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] old_addr;
  logic [31:0] pending;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic        redir;
  logic [31:0] target;

  // Branch resolves in EX and is older than the jump sitting in ID, so it wins.
  always_comb begin
    redir = branch_taken | (jump & if_id_valid & ~stall);
    if (branch_taken)
      target = {branch_target[31:2], 2'b00};
    else
      target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
  end

  assign pc4       = pc + 32'd4;
  assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? old_addr : pc;
  assign opcode    = if_id_instr[31:26];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      old_addr    <= '0;
      pending     <= '0;
      hold_instr  <= '0;
      hold_pc4    <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
    end else begin
      // Flush takes priority over stall; loads below only happen without redir.
      if (redir) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
        if_id_pc4   <= '0;
      end
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            if (redir) begin
              pc <= target;
            end else if (!stall) begin
              if_id_valid <= 1'b1;
              if_id_instr <= imem_rdata;
              if_id_pc4   <= pc4;
              pc          <= pc4;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc4   <= pc4;
              state      <= S_HOLD;
            end
          end else if (redir) begin
            // Address must stay put until the outstanding request is acked.
            old_addr <= pc;
            pending  <= target;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (redir) pending <= target;
          if (imem_ack) begin
            pc    <= redir ? target : pending;
            state <= S_REQ;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= S_REQ;
          end else if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_instr <= hold_instr;
            if_id_pc4   <= hold_pc4;
            pc          <= pc4;
            state       <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
